// File: rtl/fc_layer_seq.sv
// -----------------------------------------------------------------------------
// fc_layer_seq
// Sequential fully-connected layer. One input vector is captured, then each
// group of LANES neurons is computed by LANES MAC units stepping through the
// PREV_LAYER elements one per cycle. Bias is added, the sum is saturated to
// 2*BITWIDTH bits and optionally passed through ReLU. All groups are written
// into a result register that is presented with a valid/ready handshake.
//
// Ports
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   in_valid    : upstream vector valid
//   in_ready    : block is idle and can take a vector
//   data        : PREV_LAYER signed elements, element j at [j*BITWIDTH +: BITWIDTH]
//   weights     : weight (i,j) at [(i*PREV_LAYER+j)*BITWIDTH +: BITWIDTH], static while busy
//   bias        : bias i at [i*BITWIDTH +: BITWIDTH], static while busy
//   out_valid   : result valid, held until out_ready
//   out_ready   : downstream accepts result
//   result      : neuron i at [i*2*BITWIDTH +: 2*BITWIDTH]
//   busy        : computing (MAC or BIAS state)
// -----------------------------------------------------------------------------
module fc_layer_seq #(
    parameter int BITWIDTH   = 8,
    parameter int PREV_LAYER = 25,
    parameter int NEXT_LAYER = 2,
    parameter int LANES      = 1,
    parameter int RELU       = 0,
    parameter int ACC_W      = 2*BITWIDTH + $clog2(PREV_LAYER) + 1
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [BITWIDTH*PREV_LAYER-1:0]         data,
    input  logic [BITWIDTH*PREV_LAYER*NEXT_LAYER-1:0] weights,
    input  logic [BITWIDTH*NEXT_LAYER-1:0]         bias,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [2*BITWIDTH*NEXT_LAYER-1:0]       result,
    output logic                                   busy
);

    localparam int RW     = 2*BITWIDTH;
    localparam int GROUPS = NEXT_LAYER / LANES;
    localparam int EW     = (PREV_LAYER > 1) ? $clog2(PREV_LAYER) : 1;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [EW-1:0] LAST_ELEM  = EW'(PREV_LAYER - 1);
    localparam logic [GW-1:0] LAST_GROUP = GW'(GROUPS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-RW+1){1'b0}}, {(RW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-RW+1){1'b1}}, {(RW-1){1'b0}}};

    generate
        if ((NEXT_LAYER % LANES) != 0) begin : g_lanes_check
            $error("fc_layer_seq: LANES must divide NEXT_LAYER");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_BIAS = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    // Sign-extend one BITWIDTH element to product width; the low RW bits of the
    // product of two such values equal the full signed product.
    function automatic logic signed [RW-1:0] sext_rw(input logic [BITWIDTH-1:0] x);
        return {{BITWIDTH{x[BITWIDTH-1]}}, x};
    endfunction

    // Sign-extend one bias element to accumulator width.
    function automatic logic signed [ACC_W-1:0] sext_acc(input logic [BITWIDTH-1:0] x);
        return {{(ACC_W-BITWIDTH){x[BITWIDTH-1]}}, x};
    endfunction

    // Clamp to the RW-bit signed range, then apply optional ReLU.
    function automatic logic [RW-1:0] sat_relu(input logic signed [ACC_W-1:0] v);
        logic [RW-1:0] s;
        if (v > SAT_MAX) begin
            s = SAT_MAX[RW-1:0];
        end else if (v < SAT_MIN) begin
            s = SAT_MIN[RW-1:0];
        end else begin
            s = v[RW-1:0];
        end
        if ((RELU != 0) && s[RW-1]) begin
            s = {RW{1'b0}};
        end else begin
            s = s;
        end
        return s;
    endfunction

    state_t                          state_q, state_d;
    logic [EW-1:0]                   elem_q, elem_d;
    logic [GW-1:0]                   group_q, group_d;
    logic [BITWIDTH*PREV_LAYER-1:0]  vec_q, vec_d;
    logic [RW*NEXT_LAYER-1:0]        result_q, result_d;
    logic signed [ACC_W-1:0]         acc_q [LANES];
    logic signed [ACC_W-1:0]         acc_d [LANES];
    logic                            in_ready_q, in_ready_d;
    logic                            out_valid_q, out_valid_d;
    logic                            busy_q, busy_d;
    logic signed [RW-1:0]            prod_s [LANES];

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;

    // Per-lane product of the current element and the lane's weight.
    always_comb begin
        int d_idx;
        int w_idx;
        d_idx = int'(elem_q) * BITWIDTH;
        w_idx = 0;
        for (int k = 0; k < LANES; k++) begin
            w_idx     = ((int'(group_q) * LANES + k) * PREV_LAYER + int'(elem_q)) * BITWIDTH;
            prod_s[k] = sext_rw(vec_q[d_idx +: BITWIDTH]) * sext_rw(weights[w_idx +: BITWIDTH]);
        end
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        int slot;
        state_d  = state_q;
        elem_d   = elem_q;
        group_d  = group_q;
        vec_d    = vec_q;
        result_d = result_q;
        slot     = 0;
        for (int k = 0; k < LANES; k++) begin
            acc_d[k] = acc_q[k];
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    vec_d   = data;
                    elem_d  = {EW{1'b0}};
                    group_d = {GW{1'b0}};
                    for (int k = 0; k < LANES; k++) begin
                        acc_d[k] = {ACC_W{1'b0}};
                    end
                    state_d = S_MAC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MAC: begin
                for (int k = 0; k < LANES; k++) begin
                    acc_d[k] = acc_q[k] + {{(ACC_W-RW){prod_s[k][RW-1]}}, prod_s[k]};
                end
                if (elem_q == LAST_ELEM) begin
                    elem_d  = {EW{1'b0}};
                    state_d = S_BIAS;
                end else begin
                    elem_d  = elem_q + EW'(1);
                    state_d = S_MAC;
                end
            end
            S_BIAS: begin
                for (int k = 0; k < LANES; k++) begin
                    slot = int'(group_q) * LANES + k;
                    result_d[slot*RW +: RW] = sat_relu(acc_q[k] + sext_acc(bias[slot*BITWIDTH +: BITWIDTH]));
                    acc_d[k] = {ACC_W{1'b0}};
                end
                elem_d = {EW{1'b0}};
                if (group_q == LAST_GROUP) begin
                    state_d = S_OUT;
                end else begin
                    group_d = group_q + GW'(1);
                    state_d = S_MAC;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_OUT);
        busy_d      = (state_d == S_MAC) || (state_d == S_BIAS);
    end

    // State, datapath and output registers; reset aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            elem_q      <= {EW{1'b0}};
            group_q     <= {GW{1'b0}};
            vec_q       <= {(BITWIDTH*PREV_LAYER){1'b0}};
            result_q    <= {(RW*NEXT_LAYER){1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                acc_q[k] <= {ACC_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            group_q     <= group_d;
            vec_q       <= vec_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            for (int k = 0; k < LANES; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

endmodule

// File: tb/tb_fc_layer_seq.sv
// -----------------------------------------------------------------------------
// tb_fc_layer_seq
// Three instances share stimulus: defaults (u0), LANES=2 (u1), RELU=1 (u2).
// A table of vectors with hand-computed results is applied in a loop, then
// hand-written sequences cover backpressure, back-to-back accept and a reset
// abort in the middle of accumulation.
// -----------------------------------------------------------------------------
module tb_fc_layer_seq;

    localparam int BW = 8;
    localparam int PL = 25;
    localparam int NL = 2;

    logic                  clk;
    logic                  rst_n;
    logic                  in_valid;
    logic                  out_ready;
    logic [BW*PL-1:0]      data;
    logic [BW*PL*NL-1:0]   weights;
    logic [BW*NL-1:0]      bias;
    logic [2:0]            in_ready_w;
    logic [2:0]            out_valid_w;
    logic [2:0]            busy_w;
    logic [2*BW*NL-1:0]    res_w [3];

    fc_layer_seq u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .data(data), .weights(weights), .bias(bias), .out_valid(out_valid_w[0]),
        .out_ready(out_ready), .result(res_w[0]), .busy(busy_w[0])
    );

    fc_layer_seq #(.LANES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .data(data), .weights(weights), .bias(bias), .out_valid(out_valid_w[1]),
        .out_ready(out_ready), .result(res_w[1]), .busy(busy_w[1])
    );

    fc_layer_seq #(.RELU(1)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
        .data(data), .weights(weights), .bias(bias), .out_valid(out_valid_w[2]),
        .out_ready(out_ready), .result(res_w[2]), .busy(busy_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [BW*PL-1:0]    d;
        logic [BW*PL*NL-1:0] w;
        logic [BW*NL-1:0]    b;
        int                  e0;
        int                  e1;
        int                  r0;
        int                  r1;
    } vec_t;

    vec_t tv [5];
    int   n_vec = 0;
    int   n_err = 0;
    int   exp_lat [3] = '{52, 26, 52};

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int lo(input logic [2*BW*NL-1:0] r);
        return int'($signed(r[2*BW-1:0]));
    endfunction

    function automatic int hi(input logic [2*BW*NL-1:0] r);
        return int'($signed(r[4*BW-1:2*BW]));
    endfunction

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge clk);
        while (!(&in_ready_w) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: in_ready=%b expected 111", in_ready_w);
        end
    endtask

    // Called just after a negedge with every instance idle.
    task automatic start(input int i);
        data     = tv[i].d;
        weights  = tv[i].w;
        bias     = tv[i].b;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Waits for out_valid on each instance, checking latency and results.
    task automatic collect(input int i);
        int  cnt;
        int  lat [3];
        bit  seen [3];
        int  got0 [3];
        int  got1 [3];
        cnt = 0;
        for (int k = 0; k < 3; k++) begin
            seen[k] = 1'b0;
            lat[k]  = -1;
            got0[k] = 0;
            got1[k] = 0;
        end
        while (!(seen[0] && seen[1] && seen[2]) && cnt < 300) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!seen[k] && out_valid_w[k]) begin
                    seen[k] = 1'b1;
                    lat[k]  = cnt;
                    got0[k] = lo(res_w[k]);
                    got1[k] = hi(res_w[k]);
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            check($sformatf("v%0d u%0d latency", i, k), lat[k], exp_lat[k]);
            check($sformatf("v%0d u%0d result0", i, k), got0[k], (k == 2) ? tv[i].r0 : tv[i].e0);
            check($sformatf("v%0d u%0d result1", i, k), got1[k], (k == 2) ? tv[i].r1 : tv[i].e1);
        end
    endtask

    initial begin
        logic [BW*PL-1:0] ramp;
        logic [BW*PL-1:0] row;
        int exp_pk;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        data      = '0;
        weights   = '0;
        bias      = '0;

        for (int j = 0; j < PL; j++) begin
            ramp[j*BW +: BW] = 8'(j - 12);
        end
        row = ramp;

        tv[0] = '{d: {PL{8'h01}}, w: {(PL*NL){8'h01}}, b: {8'h03, 8'h00},
                  e0: 25, e1: 28, r0: 25, r1: 28};
        tv[1] = '{d: {PL{8'h7f}}, w: {(PL*NL){8'h7f}}, b: {8'h7f, 8'h7f},
                  e0: 32767, e1: 32767, r0: 32767, r1: 32767};
        tv[2] = '{d: {PL{8'h80}}, w: {(PL*NL){8'h7f}}, b: {8'h00, 8'h00},
                  e0: -32768, e1: -32768, r0: 0, r1: 0};
        tv[3] = '{d: ramp, w: {{PL{8'hff}}, {PL{8'h02}}}, b: {8'hfb, 8'h04},
                  e0: 4, e1: -5, r0: 4, r1: 0};
        tv[4] = '{d: ramp, w: {{PL{8'h03}}, row}, b: {8'hf9, 8'h0a},
                  e0: 1310, e1: -7, r0: 1310, r1: 0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", int'(in_ready_w[0]), 1);
        check("reset out_valid", int'(out_valid_w[0]), 0);
        check("reset busy", int'(busy_w[0]), 0);
        check("reset result", int'(res_w[0]), 0);
        check("reset u1 in_ready", int'(in_ready_w[1]), 1);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 5; i++) begin
            wait_idle();
            start(i);
            collect(i);
        end

        // Backpressure: hold out_ready low for 10 cycles in OUT
        wait_idle();
        out_ready = 1'b0;
        start(0);
        collect(0);
        exp_pk = int'({16'(tv[0].e1), 16'(tv[0].e0)});
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("bp c%0d out_valid", c), int'(out_valid_w[0]), 1);
            check($sformatf("bp c%0d in_ready", c), int'(in_ready_w[0]), 0);
            check($sformatf("bp c%0d result", c), int'(res_w[0]), exp_pk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp release out_valid", int'(out_valid_w[0]), 0);
        check("bp release in_ready", int'(in_ready_w[0]), 1);
        // Back-to-back: offer the next vector in the first idle cycle
        start(3);
        collect(3);

        // Reset abort during MAC
        wait_idle();
        start(1);
        repeat (10) @(posedge clk);
        #2;
        check("abort busy before", int'(busy_w[0]), 1);
        rst_n = 1'b0;
        #1;
        check("abort in_ready", int'(in_ready_w[0]), 1);
        check("abort out_valid", int'(out_valid_w[0]), 0);
        check("abort busy", int'(busy_w[0]), 0);
        check("abort result", int'(res_w[0]), 0);
        check("abort u1 busy", int'(busy_w[1]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_idle();
        start(4);
        collect(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fc_layer_seq.md
Name: fc_layer_seq

Overview:
- Sequential, parametrised fully-connected layer for the conv_net datapath. It replaces the fully-parallel combinational FC block.
- Holds one input vector and computes signed dot products over PREV_LAYER inputs for NEXT_LAYER neurons, using LANES time-multiplexed MAC units.
- Adds bias, optionally applies ReLU, and saturates each result to 2*BITWIDTH.
- Upstream (pool/flatten) and downstream (next FC or argmax) connect through valid/ready handshakes.

Parameters:
- BITWIDTH, 8, width of each signed data, weight and bias element.
- PREV_LAYER, 25, number of input elements per vector.
- NEXT_LAYER, 2, number of output neurons.
- LANES, 1, number of parallel MAC units. Must divide NEXT_LAYER; elaboration error otherwise.
- RELU, 0, 1 clamps negative results to 0 after saturation.
- ACC_W, 2*BITWIDTH+$clog2(PREV_LAYER)+1, accumulator width. Derived; do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- data  in  BITWIDTH*PREV_LAYER  signed elements; element j is at [j*BITWIDTH +: BITWIDTH].
- weights  in  BITWIDTH*PREV_LAYER*NEXT_LAYER  signed; weight (i,j) is at [(i*PREV_LAYER+j)*BITWIDTH +: BITWIDTH]. Must be static while busy.
- bias  in  BITWIDTH*NEXT_LAYER  signed; bias i is at [i*BITWIDTH +: BITWIDTH]. Must be static while busy.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- result  out  2*BITWIDTH*NEXT_LAYER  signed; neuron i is at [i*2*BITWIDTH +: 2*BITWIDTH].
- busy  out  1  high in MAC or BIAS state.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, all counters and accumulators=0.
- Reset asserted mid-operation aborts immediately. No partial result is ever presented.
- FSM has four states: IDLE, MAC, BIAS, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register data into an internal vector. group=0, elem=0, accumulators cleared, go to MAC.
- MAC:
  - One element per cycle. Each lane k computes acc[k] += data[elem]*weights[group*LANES+k][elem] as a full signed BITWIDTH x BITWIDTH product, sign-extended to ACC_W.
  - elem increments each cycle. After PREV_LAYER cycles (elem=PREV_LAYER-1 processed), go to BIAS.
- BIAS (1 cycle) performs, per lane:
  - v = acc + sign-extended bias.
  - Saturate v to [-2^(2*BITWIDTH-1), 2^(2*BITWIDTH-1)-1].
  - If RELU=1 and the saturated value is negative, output 0.
  - Write the result to slot group*LANES+k of the result register; clear acc.
  - If group == NEXT_LAYER/LANES-1, go to OUT. Otherwise group++, elem=0, go to MAC.
- OUT:
  - out_valid=1. result is stable and in_ready=0 until out_valid&&out_ready.
  - On that handshake, out_valid=0 on the next edge and go to IDLE. in_ready=1 in the cycle after the handshake.
- result holds its last value outside OUT. Slots are only written in BIAS.
- Latency: with G=NEXT_LAYER/LANES, out_valid rises exactly G*(PREV_LAYER+1) cycles after the accepting edge.
- Throughput: one vector per G*(PREV_LAYER+1)+2 cycles when out_ready is held high.
- in_valid while not in IDLE is ignored. The upstream must hold data until in_ready.
- Accumulation never overflows ACC_W. Saturation applies only at the BIAS step.
- Arithmetic is signed two's complement throughout.

Test Plan:
- Defaults, data=all 1, weights=all 1, bias={3,0} -> out_valid 52 cycles after accept; result[0]=25, result[1]=28.
- data=all 127, weights=all 127, bias=127 -> both results 32767 (positive saturation). data=all -128, weights=all 127 -> -32768; with RELU=1 -> 0.
- Mixed signs: data[j]=j-12, weights row0=all 2, row1=all -1, bias={-5,4} -> result[0]=4, result[1]=-5.
- Backpressure: hold out_ready=0 for 10 cycles in OUT -> out_valid and result stable, in_ready=0. Raise out_ready -> in_ready=1 next cycle; back-to-back second vector accepted and correct.
- LANES=2, defaults otherwise, same stimulus as the first scenario -> out_valid after 26 cycles with identical results.
- Assert rst_n low during MAC (cycle 10) -> all outputs return to reset values asynchronously. A new vector after release produces correct results, with no carry-over from the aborted accumulation.
